byte_stream_serializer: RTL

Serializes one packed ML-KEM byte array (32·D bytes, the output of `byte_encode`) into a stream of OUT_BYTES-wide beats over a valid/ready interface with a frame-end marker. It sits directly downstream of `byte_encode`. It gives the combinational encoder a registered, back-pressurable boundary toward the ciphertext/key output bus.

---
 rtl/ml_kem_pkg.sv | 27 ++
 rtl/byte_stream_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/ml_kem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ml_kem_pkg
//  Purpose  : Shared ML-KEM encoding constants and helpers: encoded frame
//             length and the legal coefficient widths / bus widths.
//  Revision : 1.0  initial release
// ============================================================================
package ml_kem_pkg;

    // Bit d set means coefficient width d is legal (1, 4, 5, 10, 11, 12).
    localparam logic [12:0] c_LEGAL_D_MASK = 13'b1_1100_0011_0010;

    // Bytes produced by byte_encode for one 256-coefficient polynomial.
    function automatic int enc_bytes(input int d);
        return 32 * d;
    endfunction

    function automatic bit is_legal_d(input int d);
        return (d >= 1) && (d <= 12) && c_LEGAL_D_MASK[d[3:0]];
    endfunction

    function automatic bit is_legal_out_bytes(input int ob);
        return (ob == 1) || (ob == 2) || (ob == 4) || (ob == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_stream_serializer
//  Purpose  : Registers one packed ML-KEM byte frame (32*D bytes) and streams
//             it as OUT_BYTES-wide beats over valid/ready with a last marker.
//  Revision : 1.0  initial release
// ============================================================================
module byte_stream_serializer
    import ml_kem_pkg::*;
#(
    parameter int D         = 12,
    parameter int OUT_BYTES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [enc_bytes(D)-1:0][7:0]   b_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [OUT_BYTES-1:0][7:0]      out_data_o,
    output logic                           out_last_o
);

    localparam int c_NB    = enc_bytes(D);
    localparam int c_NW    = c_NB / OUT_BYTES;
    localparam int c_CNT_W = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_NW - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // Reject illegal parameterisations at elaboration.
    generate
        if (!is_legal_d(D)) begin : g_bad_d
            $error("byte_stream_serializer: illegal D");
        end
        if (!is_legal_out_bytes(OUT_BYTES)) begin : g_bad_out_bytes
            $error("byte_stream_serializer: illegal OUT_BYTES");
        end
    endgenerate

    logic [0:0]                      r_state;
    logic [0:0]                      w_state_nxt;
    logic [c_CNT_W-1:0]              r_beat_cnt;
    logic [c_CNT_W-1:0]              w_beat_cnt_nxt;
    logic [c_NB-1:0][7:0]            r_frame;
    logic [c_NW-1:0][OUT_BYTES*8-1:0] w_beats;
    logic                            w_in_fire;
    logic                            w_out_fire;
    logic                            w_is_last;

    // Ready depends only on state; it is also held low while reset is applied.
    assign in_ready_o  = (r_state == c_ST_IDLE) && !rst_i;
    assign out_valid_o = (r_state == c_ST_SEND);
    assign w_is_last   = (r_beat_cnt == c_LAST_BEAT);
    assign out_last_o  = out_valid_o && w_is_last;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;

    // Beat view of the buffer: beat k holds bytes k*OUT_BYTES .. k*OUT_BYTES+OUT_BYTES-1,
    // lowest byte in lane 0.
    assign w_beats    = r_frame;
    assign out_data_o = w_beats[r_beat_cnt];

    // Next-state and beat counter update.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        if (r_state == c_ST_IDLE) begin
            if (w_in_fire) begin
                w_state_nxt    = c_ST_SEND;
                w_beat_cnt_nxt = '0;
            end
        end else begin
            if (w_out_fire) begin
                if (w_is_last) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
        end
    end

    // State register and beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Frame buffer captures the whole input frame on the input handshake only.
    always_ff @(posedge clk_i) begin
        if (w_in_fire) begin
            r_frame <= b_i;
        end
    end

endmodule
`default_nettype wire
